// File: rtl/memory_game_pkg.sv
// rtl/memory_game_pkg.sv - shared types and constants for the memory game controller
// Holds the controller state encoding, the round index width, the pattern
// table shown to the player each round, and the two LED frames used on loss.
package memory_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHOW,
        GAP,
        RESPOND,
        PASS,
        WIN,
        LOSE
    } state_t;

    localparam int ROUND_W = 3;

    // Entries 4..7 are reserved and stay blank.
    localparam logic [15:0] PATTERN [0:7] = '{
        16'h0044, 16'h00B2, 16'h212A, 16'hD283,
        16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

    localparam logic [15:0] LOSE_A = 16'h00FF;
    localparam logic [15:0] LOSE_B = 16'hFF00;

endpackage

// File: rtl/game_tick_gen.sv
// rtl/game_tick_gen.sv - game tick enable divider
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous clear of the divider (game restart)
//   tick - one-cycle pulse every TICK_DIV clk cycles
module game_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div;

    // A clear restarts the phase so the first tick lands TICK_DIV cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (clr || div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick = (div == DIV_LAST);

endmodule

// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - round sequencer for the 16-switch/16-LED memory game
// Ports:
//   clk, rst - system clock, asynchronous active-high reset
//   start    - begins or restarts a game from IDLE, WIN or LOSE
//   sw       - raw board switches (asynchronous, synchronised here)
//   led      - registered LED drive
//   round    - current 0-based round index
//   busy     - high while a round is in progress (SHOW/GAP/RESPOND/PASS)
//   win/lose - game outcome flags
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int TICK_DIV    = 25_000_000,
    parameter int NUM_ROUNDS  = 4,
    parameter int SHOW_TICKS  = 4,
    parameter int GAP_TICKS   = 2,
    parameter int RESP_TICKS  = 10,
    parameter int CELEB_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        sw,
    output logic [15:0]        led,
    output logic [ROUND_W-1:0] round,
    output logic               busy,
    output logic               win,
    output logic               lose
);

    localparam int TIMER_W = 16;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    state_t             state;
    logic [15:0]        sw_m;
    logic [15:0]        sw_s;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] limit;
    logic               tick;
    logic               start_ok;
    logic               last_tick;

    assign start_ok = start && (state == IDLE || state == WIN || state == LOSE);

    game_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .tick(tick)
    );

    // Terminal timer value for each timed state.
    always_comb begin
        limit = '0;
        case (state)
            SHOW:    limit = TIMER_W'(SHOW_TICKS - 1);
            GAP:     limit = TIMER_W'(GAP_TICKS - 1);
            RESPOND: limit = TIMER_W'(RESP_TICKS - 1);
            PASS:    limit = TIMER_W'(CELEB_TICKS - 1);
            default: limit = '0;
        endcase
    end

    assign last_tick = tick && (timer == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            led   <= '0;
            round <= '0;
            busy  <= 1'b0;
            win   <= 1'b0;
            lose  <= 1'b0;
            timer <= '0;
        end else if (start_ok) begin
            // Restart takes priority over a coincident tick (no LOSE toggle).
            state <= SHOW;
            led   <= PATTERN[0];
            round <= '0;
            busy  <= 1'b1;
            win   <= 1'b0;
            lose  <= 1'b0;
            timer <= '0;
        end else begin
            // busy marks exactly the timed states; transitions below override.
            if (tick && busy) begin
                timer <= timer + 1'b1;
            end
            case (state)
                SHOW: begin
                    if (last_tick) begin
                        state <= GAP;
                        led   <= '0;
                        timer <= '0;
                    end
                end
                GAP: begin
                    if (last_tick) begin
                        state <= RESPOND;
                        timer <= '0;
                    end
                end
                RESPOND: begin
                    if (last_tick) begin
                        timer <= '0;
                        if (sw_s == PATTERN[round]) begin
                            state <= PASS;
                            led   <= 16'hFFFF;
                        end else begin
                            state <= LOSE;
                            led   <= LOSE_A;
                            busy  <= 1'b0;
                            lose  <= 1'b1;
                        end
                    end
                end
                PASS: begin
                    if (last_tick) begin
                        timer <= '0;
                        if (round == LAST_ROUND) begin
                            state <= WIN;
                            busy  <= 1'b0;
                            win   <= 1'b1;
                        end else begin
                            state <= SHOW;
                            round <= round + 1'b1;
                            led   <= PATTERN[round + 1'b1];
                        end
                    end
                end
                LOSE: begin
                    if (tick) begin
                        led <= (led == LOSE_A) ? LOSE_B : LOSE_A;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb/tb_memory_game_ctrl.sv - self-checking bench for memory_game_ctrl
module tb_memory_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] sw;
    logic [15:0] led;
    logic [2:0]  round;
    logic        busy;
    logic        win;
    logic        lose;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          n;
        logic [15:0] sw;
        logic [15:0] led;
        logic [2:0]  round;
        logic        busy;
        logic        win;
        logic        lose;
    } vec_t;

    vec_t tbl[$];

    memory_game_ctrl #(
        .TICK_DIV   (4),
        .NUM_ROUNDS (4),
        .SHOW_TICKS (4),
        .GAP_TICKS  (2),
        .RESP_TICKS (10),
        .CELEB_TICKS(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sw   (sw),
        .led  (led),
        .round(round),
        .busy (busy),
        .win  (win),
        .lose (lose)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] el, input logic [2:0] er,
                         input logic eb, input logic ew, input logic elo);
        checks++;
        if ({led, round, busy, win, lose} !== {el, er, eb, ew, elo}) begin
            failures++;
            $display("FAIL %s: got led=%h round=%0d busy=%b win=%b lose=%b, want led=%h round=%0d busy=%b win=%b lose=%b",
                     nm, led, round, busy, win, lose, el, er, eb, ew, elo);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        // Full winning game; offsets in comments are cycles after the start edge.
        tbl.push_back('{15, 16'h0000, 16'h0044, 3'd0, 1'b1, 1'b0, 1'b0}); // 15 last SHOW cycle
        tbl.push_back('{1,  16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0}); // 16 GAP
        tbl.push_back('{8,  16'h0044, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0}); // 24 RESPOND
        tbl.push_back('{39, 16'h0044, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0}); // 63 last RESPOND cycle
        tbl.push_back('{1,  16'h0044, 16'hFFFF, 3'd0, 1'b1, 1'b0, 1'b0}); // 64 PASS
        tbl.push_back('{7,  16'h0044, 16'hFFFF, 3'd0, 1'b1, 1'b0, 1'b0}); // 71 last PASS cycle
        tbl.push_back('{1,  16'h00B2, 16'h00B2, 3'd1, 1'b1, 1'b0, 1'b0}); // 72 round 1 SHOW
        tbl.push_back('{64, 16'h00B2, 16'hFFFF, 3'd1, 1'b1, 1'b0, 1'b0}); // 136 PASS
        tbl.push_back('{8,  16'h212A, 16'h212A, 3'd2, 1'b1, 1'b0, 1'b0}); // 144 round 2 SHOW
        tbl.push_back('{64, 16'h212A, 16'hFFFF, 3'd2, 1'b1, 1'b0, 1'b0}); // 208 PASS
        tbl.push_back('{8,  16'hD283, 16'hD283, 3'd3, 1'b1, 1'b0, 1'b0}); // 216 round 3 SHOW
        tbl.push_back('{64, 16'hD283, 16'hFFFF, 3'd3, 1'b1, 1'b0, 1'b0}); // 280 PASS
        tbl.push_back('{7,  16'hD283, 16'hFFFF, 3'd3, 1'b1, 1'b0, 1'b0}); // 287 last PASS cycle
        tbl.push_back('{1,  16'hD283, 16'hFFFF, 3'd3, 1'b0, 1'b1, 1'b0}); // 288 WIN
        tbl.push_back('{20, 16'h0000, 16'hFFFF, 3'd3, 1'b0, 1'b1, 1'b0}); // 308 WIN held

        rst   = 1'b1;
        start = 1'b0;
        sw    = 16'h0000;
        step(2);
        check("reset_state", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(3);
        check("idle_hold", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

        pulse_start();
        check("start_show", 16'h0044, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            sw = tbl[i].sw;
            step(tbl[i].n);
            check($sformatf("win_vec[%0d]", i), tbl[i].led, tbl[i].round,
                  tbl[i].busy, tbl[i].win, tbl[i].lose);
        end

        // Restart from WIN; round 0 switches go wrong after the last edge that is judged.
        pulse_start();
        check("restart_from_win", 16'h0044, 3'd0, 1'b1, 1'b0, 1'b0);
        sw = 16'h0044;
        step(62);
        check("r0_respond", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
        sw = 16'h0000;
        step(2);
        check("latency_old_pass", 16'hFFFF, 3'd0, 1'b1, 1'b0, 1'b0);
        step(8);
        check("r1_show", 16'h00B2, 3'd1, 1'b1, 1'b0, 1'b0);
        // Extra bit 2 on; the late correction is too late to be judged.
        sw = 16'h00B6;
        step(62);
        sw = 16'h00B2;
        step(2);
        check("lose_entry", 16'h00FF, 3'd1, 1'b0, 1'b0, 1'b1);
        step(3);
        check("lose_hold_a", 16'h00FF, 3'd1, 1'b0, 1'b0, 1'b1);
        step(1);
        check("lose_toggle_b", 16'hFF00, 3'd1, 1'b0, 1'b0, 1'b1);
        step(4);
        check("lose_toggle_a", 16'h00FF, 3'd1, 1'b0, 1'b0, 1'b1);

        // Restart from LOSE off the old tick phase; SHOW must still last 16 cycles.
        step(2);
        pulse_start();
        check("restart_from_lose", 16'h0044, 3'd0, 1'b1, 1'b0, 1'b0);
        step(5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_ignored_busy", 16'h0044, 3'd0, 1'b1, 1'b0, 1'b0);
        step(9);
        check("show_end_after_restart", 16'h0044, 3'd0, 1'b1, 1'b0, 1'b0);
        step(1);
        check("gap_after_restart", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
        sw = 16'h0044;
        step(48);
        check("r0_pass_after_restart", 16'hFFFF, 3'd0, 1'b1, 1'b0, 1'b0);
        step(8);
        check("r1_show_again", 16'h00B2, 3'd1, 1'b1, 1'b0, 1'b0);
        sw = 16'h00B2;
        step(64);
        check("r1_pass_again", 16'hFFFF, 3'd1, 1'b1, 1'b0, 1'b0);
        step(8);
        check("r2_show", 16'h212A, 3'd2, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of round 2 SHOW.
        step(5);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        step(2);
        rst = 1'b0;
        step(20);
        check("idle_after_reset", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check("start_after_reset", 16'h0044, 3'd0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
